// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one low row at a time, synchronizes the
// columns, debounces a single pressed key and strobes its code once.
// Optional build macro KEYPAD_AUTOREPEAT_EN adds a periodic repeat strobe
// while a key stays held.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// SCAN       | rotating rows, sampling columns at the end of each row slot
// PRESS_DB   | row frozen, counting identical samples of the candidate key
// HELD       | key accepted, waiting for it to stop matching
// RELEASE_DB | counting consecutive non-matching samples before release

`default_nettype none

module keypad_scanner #(
   parameter int SCAN_DIV     = 10,
   parameter int DEBOUNCE_CNT = 20,
   parameter int REPEAT_CNT   = 5000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] kb_col,
   output logic [3:0] kb_row,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DB_W   = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CNT - 1);

   typedef enum logic [1:0] {
      SCAN       = 2'd0,
      PRESS_DB   = 2'd1,
      HELD       = 2'd2,
      RELEASE_DB = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        col_meta_q, col_sync_q;
   logic [1:0]        row_q, row_d;
   logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
   logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
   logic [3:0]        cand_col_q, cand_col_d;
   logic [3:0]        cand_code_q, cand_code_d;
   logic [3:0]        key_code_q, key_code_d;
   logic              key_valid_q, key_valid_d;
   logic              key_held_q, key_held_d;

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int REP_W = (REPEAT_CNT > 1) ? $clog2(REPEAT_CNT) : 1;
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CNT - 1);
   logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
`endif

   logic [3:0] col_low;
   logic       single_low;
   logic       match;
   logic [1:0] col_idx;

   // Row/column position to key legend.
   function automatic logic [3:0] map_code(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      unique case ({r, c})
         4'b00_00: code = 4'h1;
         4'b00_01: code = 4'h2;
         4'b00_10: code = 4'h3;
         4'b00_11: code = 4'hA;
         4'b01_00: code = 4'h4;
         4'b01_01: code = 4'h5;
         4'b01_10: code = 4'h6;
         4'b01_11: code = 4'hB;
         4'b10_00: code = 4'h7;
         4'b10_01: code = 4'h8;
         4'b10_10: code = 4'h9;
         4'b10_11: code = 4'hC;
         4'b11_00: code = 4'hE;
         4'b11_01: code = 4'h0;
         4'b11_10: code = 4'hF;
         default:  code = 4'hD;
      endcase
      return code;
   endfunction

   // Two-flop synchronizer for the asynchronous column inputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_meta_q <= 4'hF;
         col_sync_q <= 4'hF;
      end else begin
         col_meta_q <= kb_col;
         col_sync_q <= col_meta_q;
      end
   end

   // Column sample decode: one-hot-low detection and column index.
   always_comb begin
      col_low    = ~col_sync_q;
      single_low = (col_low != 4'h0) && ((col_low & (col_low - 4'd1)) == 4'h0);
      match      = (col_sync_q == cand_col_q);
      col_idx    = 2'd0;
      unique case (col_low)
         4'b0010: col_idx = 2'd1;
         4'b0100: col_idx = 2'd2;
         4'b1000: col_idx = 2'd3;
         default: col_idx = 2'd0;
      endcase
   end

   // FSM state and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= SCAN;
         row_q       <= 2'd0;
         scan_cnt_q  <= '0;
         db_cnt_q    <= '0;
         cand_col_q  <= 4'hF;
         cand_code_q <= 4'h0;
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         scan_cnt_q  <= scan_cnt_d;
         db_cnt_q    <= db_cnt_d;
         cand_col_q  <= cand_col_d;
         cand_code_q <= cand_code_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
      end
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   // Repeat interval counter, restarted at each initial acceptance.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) rep_cnt_q <= '0;
      else       rep_cnt_q <= rep_cnt_d;
   end
`endif

   // Next-state logic for scanning, debouncing and strobing.
   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      scan_cnt_d  = scan_cnt_q;
      db_cnt_d    = db_cnt_q;
      cand_col_d  = cand_col_q;
      cand_code_d = cand_code_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_d   = rep_cnt_q;
`endif
      unique case (state_q)
         SCAN: begin
            if (scan_cnt_q == SCAN_LAST) begin
               scan_cnt_d = '0;
               if (single_low) begin
                  // Row stays frozen; debounce on the same row.
                  state_d     = PRESS_DB;
                  cand_col_d  = col_sync_q;
                  cand_code_d = map_code(row_q, col_idx);
                  db_cnt_d    = '0;
               end else begin
                  row_d = row_q + 2'd1;
               end
            end else begin
               scan_cnt_d = scan_cnt_q + SCAN_W'(1);
            end
         end
         PRESS_DB: begin
            if (match) begin
               if (db_cnt_q == DB_LAST) begin
                  state_d     = HELD;
                  db_cnt_d    = '0;
                  key_code_d  = cand_code_q;
                  key_valid_d = 1'b1;
                  key_held_d  = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                  rep_cnt_d   = '0;
`endif
               end else begin
                  db_cnt_d = db_cnt_q + DB_W'(1);
               end
            end else begin
               state_d  = SCAN;
               db_cnt_d = '0;
            end
         end
         HELD: begin
            if (!match) begin
               // The first non-matching sample already counts toward release.
               if (DEBOUNCE_CNT == 1) begin
                  state_d    = SCAN;
                  key_held_d = 1'b0;
                  row_d      = 2'd0;
                  scan_cnt_d = '0;
                  db_cnt_d   = '0;
               end else begin
                  state_d  = RELEASE_DB;
                  db_cnt_d = DB_W'(1);
               end
            end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
               if (rep_cnt_q == REP_LAST) begin
                  rep_cnt_d   = '0;
                  key_valid_d = 1'b1;
               end else begin
                  rep_cnt_d = rep_cnt_q + REP_W'(1);
               end
`endif
            end
         end
         RELEASE_DB: begin
            if (match) begin
               state_d  = HELD;
               db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
               state_d    = SCAN;
               key_held_d = 1'b0;
               row_d      = 2'd0;
               scan_cnt_d = '0;
               db_cnt_d   = '0;
            end else begin
               db_cnt_d = db_cnt_q + DB_W'(1);
            end
         end
         default: state_d = SCAN;
      endcase
   end

   assign kb_row    = ~(4'b0001 << row_q);
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives the columns from
// kb_row; expected key codes are queued at stimulus time and a monitor pops
// and compares them on every key_valid strobe.

`timescale 1ns/1ps

module tb_keypad_scanner;

   logic       clk;
   logic       reset;
   logic [3:0] kb_col;
   logic [3:0] kb_row;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   logic [15:0] press_mask;
   logic [3:0]  exp_q[$];
   int          errors = 0;
   int          checks = 0;
   int          strobe_cnt = 0;

   keypad_scanner #(
      .SCAN_DIV    (10),
      .DEBOUNCE_CNT(20),
      .REPEAT_CNT  (5000)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .kb_col   (kb_col),
      .kb_row   (kb_row),
      .key_code (key_code),
      .key_valid(key_valid),
      .key_held (key_held)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad matrix: a pressed switch pulls its column low when its row is low.
   always_comb begin
      kb_col = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (press_mask[r*4+c] && !kb_row[r]) kb_col[c] = 1'b0;
   end

   // Strobe monitor.
   always @(negedge clk) begin
      if (!reset && key_valid) begin
         strobe_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL strobe_unexpected: got code %h, expected no strobe", key_code);
         end else begin
            logic [3:0] e;
            e = exp_q.pop_front();
            if (key_code !== e) begin
               errors++;
               $display("FAIL strobe_code: got %h, expected %h", key_code, e);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic press(input int r, input int c);
      press_mask[r*4+c] = 1'b1;
   endtask

   task automatic wait_held(input logic lvl, input int max_cyc, input string name);
      int n;
      n = 0;
      while (key_held !== lvl && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'd0, key_held}, {31'd0, lvl});
   endtask

   task automatic wait_row(input logic [3:0] pat, input logic eq, input string name);
      int n;
      n = 0;
      while (((kb_row == pat) != eq) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'd0, (kb_row == pat)}, {31'd0, eq});
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_kb_row"},    {28'd0, kb_row},    32'hE);
      check({tag, "_key_code"},  {28'd0, key_code},  32'h0);
      check({tag, "_key_valid"}, {31'd0, key_valid}, 32'h0);
      check({tag, "_key_held"},  {31'd0, key_held},  32'h0);
   endtask

   initial begin
      logic [3:0] seen;
      int         s0;
      reset      = 1'b1;
      press_mask = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b0;
      check("scan_row0", {28'd0, kb_row}, 32'hE);
      repeat (10) @(posedge clk); @(negedge clk);
      check("scan_row1", {28'd0, kb_row}, 32'hD);
      repeat (10) @(posedge clk); @(negedge clk);
      check("scan_row2", {28'd0, kb_row}, 32'hB);
      repeat (10) @(posedge clk); @(negedge clk);
      check("scan_row3", {28'd0, kb_row}, 32'h7);
      repeat (10) @(posedge clk); @(negedge clk);
      check("scan_wrap", {28'd0, kb_row}, 32'hE);

      // Clean press of key 6, held, then released.
      exp_q.push_back(4'h6);
      press(1, 2);
      wait_held(1'b1, 200, "k6_held_rise");
      repeat (50) @(negedge clk);
      check("k6_held_during", {31'd0, key_held}, 32'h1);
      check("k6_code", {28'd0, key_code}, 32'h6);
      press_mask = '0;
      repeat (15) @(posedge clk); @(negedge clk);
      check("k6_held_before_db", {31'd0, key_held}, 32'h1);
      repeat (10) @(posedge clk); @(negedge clk);
      check("k6_held_after_db", {31'd0, key_held}, 32'h0);

      // Bouncing press of key 0.
      exp_q.push_back(4'h0);
      for (int i = 0; i < 5; i++) begin
         press(3, 1);
         repeat (3) @(negedge clk);
         press_mask = '0;
         repeat (3) @(negedge clk);
      end
      press(3, 1);
      wait_held(1'b1, 300, "k0_held_rise");
      check("k0_code", {28'd0, key_code}, 32'h0);
      repeat (10) @(negedge clk);
      press_mask = '0;
      wait_held(1'b0, 100, "k0_held_fall");

      // Two keys in the same row: ignored, scanning continues.
      press(0, 0);
      press(0, 3);
      seen = 4'h0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         for (int r = 0; r < 4; r++) if (kb_row == ~(4'b0001 << r)) seen[r] = 1'b1;
      end
      check("dual_rows_seen", {28'd0, seen}, 32'hF);
      check("dual_no_held", {31'd0, key_held}, 32'h0);
      press_mask = '0;
      repeat (5) @(negedge clk);

      // Reset 8 cycles into debouncing key 9.
      wait_row(4'hB, 1'b0, "k9_row2_leave");
      press(2, 2);
      wait_row(4'hB, 1'b1, "k9_row2_enter");
      repeat (18) @(posedge clk);
      @(negedge clk);
      check("k9_row_frozen", {28'd0, kb_row}, 32'hB);
      reset = 1'b1;
      @(negedge clk);
      check_reset_outputs("k9_reset");
      press_mask = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("k9_restart_row0", {28'd0, kb_row}, 32'hE);
      repeat (60) @(negedge clk);
      check("k9_no_held", {31'd0, key_held}, 32'h0);

      // Key 5 with a glitch back to pressed during release debounce.
      exp_q.push_back(4'h5);
      press(1, 1);
      wait_held(1'b1, 200, "k5_held_rise");
      repeat (5) @(negedge clk);
      press_mask = '0;
      repeat (5) @(posedge clk); @(negedge clk);
      press(1, 1);
      repeat (10) @(negedge clk);
      check("k5_held_glitch", {31'd0, key_held}, 32'h1);
      press_mask = '0;
      repeat (15) @(posedge clk); @(negedge clk);
      check("k5_held_before_db", {31'd0, key_held}, 32'h1);
      repeat (10) @(posedge clk); @(negedge clk);
      check("k5_held_after_db", {31'd0, key_held}, 32'h0);

      // Long hold of key A: one strobe, or three with auto-repeat.
      s0 = strobe_cnt;
      exp_q.push_back(4'hA);
`ifdef KEYPAD_AUTOREPEAT_EN
      exp_q.push_back(4'hA);
      exp_q.push_back(4'hA);
`endif
      press(0, 3);
      wait_held(1'b1, 200, "kA_held_rise");
      repeat (12000) @(negedge clk);
      press_mask = '0;
      wait_held(1'b0, 100, "kA_held_fall");
`ifdef KEYPAD_AUTOREPEAT_EN
      check("kA_strobes", strobe_cnt - s0, 32'd3);
`else
      check("kA_strobes", strobe_cnt - s0, 32'd1);
`endif
      repeat (20) @(negedge clk);

      check("queue_drained", exp_q.size(), 32'd0);
`ifdef KEYPAD_AUTOREPEAT_EN
      check("total_strobes", strobe_cnt, 32'd6);
`else
      check("total_strobes", strobe_cnt, 32'd4);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
